// File: rtl/dct8x8_transpose_ctrl_pkg.sv
// Shared definitions for the 8x8 transpose buffer controller: FSM states,
// block geometry and the line-index helper used by the storage array.
package dct8x8_transpose_ctrl_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam int unsigned BEATS_PER_BLOCK = 4;
  localparam int unsigned LINES_PER_BEAT  = 2;
  localparam int unsigned BLK_DIM         = 8;
  localparam int unsigned LANES_PER_BEAT  = LINES_PER_BEAT * BLK_DIM;

  // Line number inside the 8x8 block for half h of line pair p.
  function automatic logic [2:0] line_idx(input logic [1:0] pair, input logic half);
    return {pair, half};
  endfunction

endpackage

// File: rtl/dct8x8_buf_data.sv
// 8x8 element storage with row/column access. One line pair is written per
// strobe and one line pair is read combinationally, both in the same orientation.
module dct8x8_buf_data
  import dct8x8_transpose_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                 clk_i,
  input  logic                                 row_i,
  input  logic                                 wr_en_i,
  input  logic [1:0]                           wr_ptr_i,
  input  logic [LANES_PER_BEAT*DATA_WIDTH-1:0] wr_data_i,
  input  logic [1:0]                           rd_ptr_i,
  output logic [LANES_PER_BEAT*DATA_WIDTH-1:0] rd_data_o
);

  // mem_q[row][col]; contents are not reset.
  logic [DATA_WIDTH-1:0] mem_q [BLK_DIM][BLK_DIM];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int unsigned h = 0; h < LINES_PER_BEAT; h++) begin
        for (int unsigned j = 0; j < BLK_DIM; j++) begin
          if (row_i) begin
            mem_q[line_idx(wr_ptr_i, h[0])][j[2:0]] <=
              wr_data_i[(h*BLK_DIM + j)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            mem_q[j[2:0]][line_idx(wr_ptr_i, h[0])] <=
              wr_data_i[(h*BLK_DIM + j)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned h = 0; h < LINES_PER_BEAT; h++) begin
      for (int unsigned j = 0; j < BLK_DIM; j++) begin
        if (row_i) begin
          rd_data_o[(h*BLK_DIM + j)*DATA_WIDTH +: DATA_WIDTH] =
            mem_q[line_idx(rd_ptr_i, h[0])][j[2:0]];
        end else begin
          rd_data_o[(h*BLK_DIM + j)*DATA_WIDTH +: DATA_WIDTH] =
            mem_q[j[2:0]][line_idx(rd_ptr_i, h[0])];
        end
      end
    end
  end

endmodule

// File: rtl/dct8x8_transpose_ctrl.sv
// 8x8 transpose buffer controller: blocks of four two-line beats are written in
// alternating row/column orientation and read back in the opposite orientation.
module dct8x8_transpose_ctrl
  import dct8x8_transpose_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [16*DATA_WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [16*DATA_WIDTH-1:0]   out_data,
  output logic                       out_last
);

  localparam logic [2:0] LAST_WR  = 3'(BEATS_PER_BLOCK - 1);
  localparam logic [2:0] FULL_WR  = 3'(BEATS_PER_BLOCK);
  localparam logic [1:0] LAST_RD  = 2'(BEATS_PER_BLOCK - 1);

  state_e     state_q, state_d;
  logic [2:0] wr_cnt_q, wr_cnt_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic       wr_row_q, wr_row_d;
  logic       in_acc;
  logic       wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      wr_row_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_row_q <= wr_row_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_row_d  = wr_row_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_acc    = 1'b0;
    case (state_q)
      ST_FILL: begin
        in_ready = 1'b1;
        in_acc   = in_valid;
        if (in_acc) begin
          if (wr_cnt_q == LAST_WR) begin
            state_d  = ST_DRAIN;
            wr_cnt_d = '0;
            rd_ptr_d = '0;
            wr_row_d = !wr_row_q;
          end else begin
            wr_cnt_d = wr_cnt_q + 3'd1;
          end
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_ptr_q == LAST_RD);
        // The next block's pair k overwrites exactly the pair read at rd_ptr=k,
        // so a write may only land on a pair already read or being read now.
        in_ready  = (wr_cnt_q < {1'b0, rd_ptr_q}) ||
                    ((wr_cnt_q == {1'b0, rd_ptr_q}) && out_ready);
        in_acc    = in_valid && in_ready;
        if (in_acc) begin
          wr_cnt_d = wr_cnt_q + 3'd1;
        end
        if (out_ready) begin
          if (rd_ptr_q == LAST_RD) begin
            rd_ptr_d = '0;
            if (wr_cnt_d == FULL_WR) begin
              wr_cnt_d = '0;
              wr_row_d = !wr_row_q;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 2'd1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign wr_en = in_valid && in_ready;

  // Reads use the current write orientation: the drained block was written in
  // the opposite one, which is exactly the transposed access.
  dct8x8_buf_data #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk_i     (clk),
    .row_i     (wr_row_q),
    .wr_en_i   (wr_en),
    .wr_ptr_i  (wr_cnt_q[1:0]),
    .wr_data_i (in_data),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (out_data)
  );

endmodule
